// File: rtl/calculator_pipe_fsm.sv
// calculator_pipe_fsm: accumulating signed calculator engine between the
// debounced button/switch front end and the display path.
// Optional feature macro: DIVIDE_EN. When defined, CENTER selects a
// multi-cycle signed restoring divider and busy is driven; when undefined,
// CENTER is a no-op and busy is tied low.

package calculator_pkg;
    localparam int UP     = 0;
    localparam int DOWN   = 1;
    localparam int LEFT   = 2;
    localparam int RIGHT  = 3;
    localparam int CENTER = 4;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_MUL  = 3'd1,
        OP_EQ   = 3'd2,
        OP_ADD  = 3'd3,
        OP_SUB  = 3'd4,
        OP_DIV  = 3'd5
    } op_e;

    // Multi-hot buttons resolve by priority UP > DOWN > LEFT > RIGHT > CENTER.
    function automatic op_e decode_op(input logic [4:0] btn);
        if (btn[UP])          return OP_MUL;
        else if (btn[DOWN])   return OP_EQ;
        else if (btn[LEFT])   return OP_ADD;
        else if (btn[RIGHT])  return OP_SUB;
        else if (btn[CENTER]) return OP_DIV;
        else                  return OP_NONE;
    endfunction
endpackage

//  state     | meaning
//  ----------+-----------------------------------------------------------
//  S_IDLE    | no calculation open; next start loads accum, clears overflow
//  S_WAIT_OP | pending_op is armed; next start applies it to accum
//  S_DIVIDE  | restoring divider iterating, one quotient bit per cycle
module calculator_pipe_fsm
    import calculator_pkg::*;
#(
    parameter int BITS    = 32,
    parameter int SW_BITS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [4:0]         buttons,
    input  logic [SW_BITS-1:0] switch,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic [BITS-1:0]    accum
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_OP = 2'd1,
        S_DIVIDE  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [BITS-1:0] accum_q, accum_d;
    logic            overflow_q, overflow_d;
    logic            done_q, done_d;
    op_e             op_q, op_d;

    logic [BITS-1:0]                operand;
    op_e                            new_op;
    logic [BITS:0]                  sum;
    logic [BITS:0]                  diff;
    logic signed [BITS+SW_BITS-1:0] prod;
    logic                           add_ovf;
    logic                           sub_ovf;
    logic                           mul_ovf;

    assign operand = {{(BITS-SW_BITS){switch[SW_BITS-1]}}, switch};
    assign new_op  = decode_op(buttons);

    // One guard bit for add/sub; the full-width product keeps every upper bit
    // so overflow is "upper bits are not a sign extension of bit BITS-1".
    assign sum  = {accum_q[BITS-1], accum_q} + {operand[BITS-1], operand};
    assign diff = {accum_q[BITS-1], accum_q} - {operand[BITS-1], operand};
    assign prod = $signed({{SW_BITS{accum_q[BITS-1]}}, accum_q})
                * $signed({{SW_BITS{operand[BITS-1]}}, operand});

    assign add_ovf = sum[BITS] ^ sum[BITS-1];
    assign sub_ovf = diff[BITS] ^ diff[BITS-1];
    assign mul_ovf = !((&prod[BITS+SW_BITS-1:BITS-1]) || !(|prod[BITS+SW_BITS-1:BITS-1]));

`ifdef DIVIDE_EN
    localparam int CNT_W = $clog2(BITS);

    // quo_q starts as the dividend magnitude and is shifted left one bit per
    // cycle while the quotient bits fill in from the right.
    logic [BITS-1:0]    quo_q, quo_d;
    logic [SW_BITS-1:0] rem_q, rem_d;
    logic [SW_BITS-1:0] dvsr_q, dvsr_d;
    logic               neg_q, neg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [BITS-1:0]    acc_mag;
    logic [SW_BITS-1:0] sw_mag;
    logic [SW_BITS:0]   rem_shift;
    logic               rem_ge;
    logic [SW_BITS-1:0] rem_sub;
    logic [BITS-1:0]    quo_next;
    logic [BITS-1:0]    div_result;
    logic               div_ovf;

    assign acc_mag    = accum_q[BITS-1] ? -accum_q : accum_q;
    assign sw_mag     = switch[SW_BITS-1] ? -switch : switch;
    assign rem_shift  = {rem_q, quo_q[BITS-1]};
    assign rem_ge     = rem_shift >= {1'b0, dvsr_q};
    // The remainder stays below the divisor, so the subtraction fits SW_BITS.
    assign rem_sub    = rem_shift[SW_BITS-1:0] - dvsr_q;
    assign quo_next   = {quo_q[BITS-2:0], rem_ge};
    assign div_result = neg_q ? -quo_next : quo_next;
    // Only -2^(BITS-1) / -1 yields a positive quotient with the top bit set.
    assign div_ovf    = !neg_q && quo_next[BITS-1];
    assign busy       = (state_q == S_DIVIDE);
`else
    assign busy = 1'b0;
`endif

    // Next-state, datapath and done-pulse decode.
    always_comb begin
        state_d    = state_q;
        accum_d    = accum_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        op_d       = op_q;
`ifdef DIVIDE_EN
        quo_d      = quo_q;
        rem_d      = rem_q;
        dvsr_d     = dvsr_q;
        neg_d      = neg_q;
        cnt_d      = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accum_d    = operand;
                    overflow_d = 1'b0;
                    op_d       = new_op;
                    if (new_op != OP_EQ) state_d = S_WAIT_OP;
                end
            end
            S_WAIT_OP: begin
                if (start) begin
                    op_d = new_op;
                    if (new_op == OP_EQ) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                    case (op_q)
                        OP_MUL: begin
                            accum_d    = prod[BITS-1:0];
                            overflow_d = overflow_q | mul_ovf;
                        end
                        OP_ADD: begin
                            accum_d    = sum[BITS-1:0];
                            overflow_d = overflow_q | add_ovf;
                        end
                        OP_SUB: begin
                            accum_d    = diff[BITS-1:0];
                            overflow_d = overflow_q | sub_ovf;
                        end
`ifdef DIVIDE_EN
                        OP_DIV: begin
                            if (switch == '0) begin
                                overflow_d = 1'b1;
                            end else begin
                                // The follow-on op is already in op_d; it is
                                // acted on once the quotient is written.
                                done_d  = 1'b0;
                                state_d = S_DIVIDE;
                                quo_d   = acc_mag;
                                rem_d   = '0;
                                dvsr_d  = sw_mag;
                                neg_d   = accum_q[BITS-1] ^ switch[SW_BITS-1];
                                cnt_d   = CNT_W'(BITS-1);
                            end
                        end
`endif
                        default: ;
                    endcase
                end
            end
            S_DIVIDE: begin
`ifdef DIVIDE_EN
                quo_d = quo_next;
                rem_d = rem_ge ? rem_sub : rem_shift[SW_BITS-1:0];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    accum_d    = div_result;
                    overflow_d = overflow_q | div_ovf;
                    if (op_q == OP_EQ) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT_OP;
                    end
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and accumulator registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            accum_q    <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            op_q       <= OP_NONE;
        end else begin
            state_q    <= state_d;
            accum_q    <= accum_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            op_q       <= op_d;
        end
    end

`ifdef DIVIDE_EN
    // Divider working registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvsr_q <= '0;
            neg_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvsr_q <= dvsr_d;
            neg_q  <= neg_d;
            cnt_q  <= cnt_d;
        end
    end
`endif

    assign done     = done_q;
    assign overflow = overflow_q;
    assign accum    = accum_q;

endmodule

// File: doc/calculator_pipe_fsm.md
# calculator_pipe_fsm

Parametrised next-generation calculator engine for the board-level calculator demo. It sits between the debounced button/switch front end and the seven-segment/LED display path. It accumulates signed operands entered on the switches under button-selected operations and adds the following:
- configurable widths
- asynchronous reset
- a sticky overflow flag
- an explicit busy indication
- an optional multi-cycle signed divider

## Interface
Parameters:
- BITS, 32, accumulator width; must be > SW_BITS.
- SW_BITS, 16, switch operand width; the operand is signed and sign-extended to BITS.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle pulse: an operand/operation pair is valid on buttons/switch.
- buttons  input  5  one-hot operation select; bit indices come from calculator_pkg (UP, DOWN, LEFT, RIGHT, CENTER).
- switch  input  SW_BITS  signed operand.
- busy  output  1  high while a divide iterates; start is ignored while high.
- done  output  1  one-cycle pulse when a calculation completes.
- overflow  output  1  sticky flag: a result was not representable in signed BITS.
- accum  output  BITS  current accumulator value.

## Operation
- Operations:
  - UP = multiply.
  - LEFT = add.
  - RIGHT = subtract.
  - CENTER = divide (only when DIVIDE_EN is defined).
  - DOWN = equals.
- Multi-hot buttons resolve by priority UP > DOWN > LEFT > RIGHT > CENTER. All-zero buttons mean "no operation".
- An operation is stored as pending_op. It is applied to accum with the next operand.
- IDLE:
  - On start: accum <= sext(switch), overflow <= 0, pending_op <= buttons.
  - If buttons[DOWN], stay in IDLE; the value is loaded and no done pulse is issued.
  - Otherwise go to WAIT_OP.
- WAIT_OP:
  - On start with pending UP, LEFT or RIGHT: accum <= accum op sext(switch), then pending_op <= buttons.
  - If the new buttons[DOWN]: pulse done and go to IDLE. Otherwise stay in WAIT_OP.
  - Pending op that is none, or CENTER with DIVIDE_EN undefined: accum unchanged; the same next-state rule applies.
  - Pending CENTER with DIVIDE_EN defined and switch != 0: latch the divisor and the new buttons, then go to DIVIDE.
- DIVIDE:
  - busy = 1 for exactly BITS cycles; one bit per cycle via a restoring divide on magnitudes.
  - On the final cycle: accum <= signed quotient, truncated toward zero.
  - Then apply the latched buttons: DOWN pulses done and goes to IDLE; anything else goes to WAIT_OP.
- Arithmetic and overflow:
  - Add/sub are computed at BITS+1 bits; the product at BITS+SW_BITS bits.
  - accum takes the low BITS bits, i.e. two's-complement wrap.
  - overflow is set if the discarded upper bits are not a sign extension of bit BITS-1.
  - overflow is cleared only by an IDLE load or by rst.
- Divide special cases:
  - Divide by zero: accum unchanged, overflow <= 1, DIVIDE is not entered, and the next-state rule is applied immediately.
  - -2^(BITS-1) / -1: result -2^(BITS-1), overflow <= 1.
- start while busy is dropped entirely, with no effect on state.

## Timing
- Reset values: state IDLE, accum 0, pending_op 0, busy 0, done 0, overflow 0.
- rst is asynchronous. Asserting it mid-divide aborts the divide and forces the reset values immediately; the first operation occurs on the first rising edge after deassertion.
- Add, sub and mul:
  - accum is updated at the edge sampling start.
  - done is high the cycle after that edge, coincident with the new accum, for exactly one cycle.
- Divide:
  - busy rises the cycle after the start edge and stays high for BITS cycles.
  - accum and done update on the edge where busy falls, i.e. BITS+1 edges after start.
- done and busy are never high in the same cycle. Back-to-back start pulses are accepted every cycle when not busy.

## Configuration
- DIVIDE_EN defined: CENTER selects signed divide; the DIVIDE state, divider datapath and busy logic are present.
- DIVIDE_EN undefined:
  - CENTER is a no-op operation and busy is tied to 0.
  - No divider logic is synthesised.
  - All other behaviour is identical.

## Test plan
Directed scenarios, with BITS=32 and SW_BITS=16:
- Add: start(5, LEFT), start(7, DOWN) -> accum 12, one done pulse, overflow 0, state IDLE.
- Chain: start(3, UP), start(-4, RIGHT), start(10, DOWN) -> accum -12 after the second pulse, -22 after the third; a single done.
- Overflow: start(32767, UP), start(32767, UP), start(32767, DOWN) -> accum = low 32 bits of 32767^3, overflow 1, held until the next IDLE load.
- Divide (DIVIDE_EN defined): start(-100, CENTER), start(7, DOWN) -> busy high for 32 cycles, then accum -14 and done; a start during busy is ignored.
- Divide by zero: start(9, CENTER), start(0, DOWN) -> busy never high, accum 9, overflow 1, done next cycle.
- Reset mid-divide: assert rst on divide cycle 10 -> busy, done, overflow and accum go to 0 asynchronously; after release, start(5, DOWN) loads 5.
